// File: rtl/reorder_seq.sv
// -----------------------------------------------------------------------------
// reorder_seq
//   Sequencer for the reorder datapath. It holds four side-info banks, one per
//   granule/channel. On a start request it streams that bank's coefficient
//   indices to the datapath. It then waits until every issued index has come
//   back, and finally pulses done.
//
//   Optional feature (compile-time macro REORDER_SEQ_SKIP_EN):
//     defined   -> issue only min(2*big_values, 576) indices
//     undefined -> always issue 576 indices
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   si_valid, si_grch           side-info write strobe and target bank
//   si_window_switching_flag,
//   si_block_type,
//   si_mixed_block_flag,
//   si_big_values               side-info fields written on si_valid
//   start, start_grch           request to sequence one bank
//   stall                       downstream hold; no index issued while high
//   rd_v                        completion strobe from the datapath
//   grch_out, is_pos, din_v     index stream to the datapath
//   window_switching_flag,
//   block_type,
//   mixed_block_flag,
//   big_values                  registered fields of the active bank
//   busy, done, err             run in progress, completion pulse, error pulse
// -----------------------------------------------------------------------------
module reorder_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       si_valid,
  input  logic [1:0] si_grch,
  input  logic       si_window_switching_flag,
  input  logic [1:0] si_block_type,
  input  logic       si_mixed_block_flag,
  input  logic [8:0] si_big_values,
  input  logic       start,
  input  logic [1:0] start_grch,
  input  logic       stall,
  input  logic       rd_v,
  output logic [1:0] grch_out,
  output logic [9:0] is_pos,
  output logic       din_v,
  output logic       window_switching_flag,
  output logic [1:0] block_type,
  output logic       mixed_block_flag,
  output logic [8:0] big_values,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       wsf;
    logic [1:0] bt;
    logic       mbf;
    logic [8:0] bv;
  } side_info_t;

  localparam logic [9:0] MAX_IDX = 10'd576;

  state_t     r_state;
  state_t     w_next;
  side_info_t r_bank [4];
  logic [3:0] r_loaded;
  side_info_t r_active;
  logic [1:0] r_grch;
  logic [9:0] r_index;
  logic [2:0] r_count;
  logic       r_err;

  side_info_t w_si_in;
  side_info_t w_start_info;
  logic       w_busy;
  logic       w_si_blocked;
  logic       w_si_write;
  logic       w_bypass;
  logic       w_start_req;
  logic       w_start_ok;
  logic       w_start_err;
  logic       w_rd_err;
  logic [9:0] w_n;
  logic       w_issue;

  assign w_si_in = {si_window_switching_flag, si_block_type,
                    si_mixed_block_flag, si_big_values};

  assign w_busy = (r_state == S_ISSUE) || (r_state == S_DRAIN);

  // The bank being sequenced is frozen while a run is in progress.
  assign w_si_blocked = si_valid && w_busy && (si_grch == r_grch);
  assign w_si_write   = si_valid && !w_si_blocked;

  // A write and a start on the same bank in the same cycle use the new data.
  assign w_bypass     = si_valid && (si_grch == start_grch);
  assign w_start_req  = (r_state == S_IDLE) && start;
  assign w_start_ok   = w_start_req && (r_loaded[start_grch] || w_bypass);
  assign w_start_err  = w_start_req && !(r_loaded[start_grch] || w_bypass);
  assign w_start_info = w_bypass ? w_si_in : r_bank[start_grch];

  // A return with nothing outstanding is a protocol error and is ignored.
  assign w_rd_err = rd_v && (r_count == 3'd0);

`ifdef REORDER_SEQ_SKIP_EN
  logic [9:0] w_twice_bv;
  assign w_twice_bv = {r_active.bv, 1'b0};
  assign w_n        = (w_twice_bv > MAX_IDX) ? MAX_IDX : w_twice_bv;
`else
  assign w_n = MAX_IDX;
`endif

  assign w_issue = (r_state == S_ISSUE) && !stall && (w_n != 10'd0);

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path covered,
    // so no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_n == 10'd0)                              w_next = S_DRAIN;
        else if (!stall && (r_index == w_n - 10'd1))   w_next = S_DRAIN;
      end
      S_DRAIN: if (r_count == 3'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples values from before the clock edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_loaded <= '0;
      r_active <= '0;
      r_grch   <= '0;
      r_index  <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_si_blocked || w_start_err || w_rd_err;

      // A completed bank must be reloaded before it can run again. A write in
      // the same cycle marks the bank loaded again, so it takes priority.
      if (r_state == S_DONE) r_loaded[r_grch] <= 1'b0;
      if (w_si_write)        r_loaded[si_grch] <= 1'b1;

      if (w_start_ok) begin
        r_active <= w_start_info;
        r_grch   <= start_grch;
        r_index  <= '0;
      end else if (w_issue) begin
        r_index  <= r_index + 10'd1;
      end

      if (!w_rd_err) begin
        if (w_issue && !rd_v)      r_count <= r_count + 3'd1;
        else if (!w_issue && rd_v) r_count <= r_count - 3'd1;
      end
    end
  end

  // NOTE: the bank storage has no reset. The loaded bits already mark every
  // bank invalid after reset, so this storage can map onto plain RAM or flops.
  always_ff @(posedge clk) begin
    if (w_si_write) r_bank[si_grch] <= w_si_in;
  end

  assign din_v    = w_issue;
  assign is_pos   = r_index;
  assign grch_out = r_grch;
  assign busy     = w_busy;
  assign done     = (r_state == S_DONE);
  assign err      = r_err;

  assign window_switching_flag = r_active.wsf;
  assign block_type            = r_active.bt;
  assign mixed_block_flag      = r_active.mbf;
  assign big_values            = r_active.bv;

endmodule

// File: tb/tb_reorder_seq.sv
// -----------------------------------------------------------------------------
// tb_reorder_seq
//   Directed self-checking bench for reorder_seq. The datapath is modelled as
//   a fixed three-cycle delay from din_v to rd_v. Inputs are driven on the
//   falling edge, and outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_reorder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       si_valid;
  logic [1:0] si_grch;
  logic       si_wsf;
  logic [1:0] si_bt;
  logic       si_mbf;
  logic [8:0] si_bv;
  logic       start;
  logic [1:0] start_grch;
  logic       stall;
  logic       rd_v;
  logic [1:0] grch_out;
  logic [9:0] is_pos;
  logic       din_v;
  logic       window_switching_flag;
  logic [1:0] block_type;
  logic       mixed_block_flag;
  logic [8:0] big_values;
  logic       busy;
  logic       done;
  logic       err;

  logic [2:0] rd_pipe = '0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Datapath model: each issued index returns three cycles later.
  always @(posedge clk) rd_pipe <= {rd_pipe[1:0], din_v};
  assign rd_v = rd_pipe[2];

  reorder_seq dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .si_valid                 (si_valid),
    .si_grch                  (si_grch),
    .si_window_switching_flag (si_wsf),
    .si_block_type            (si_bt),
    .si_mixed_block_flag      (si_mbf),
    .si_big_values            (si_bv),
    .start                    (start),
    .start_grch               (start_grch),
    .stall                    (stall),
    .rd_v                     (rd_v),
    .grch_out                 (grch_out),
    .is_pos                   (is_pos),
    .din_v                    (din_v),
    .window_switching_flag    (window_switching_flag),
    .block_type               (block_type),
    .mixed_block_flag         (mixed_block_flag),
    .big_values               (big_values),
    .busy                     (busy),
    .done                     (done),
    .err                      (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Number of indices a run should issue for a given big_values.
  function automatic int exp_n(input int bv);
`ifdef REORDER_SEQ_SKIP_EN
    return (2 * bv > 576) ? 576 : 2 * bv;
`else
    return 576;
`endif
  endfunction

  task automatic load_bank(input logic [1:0] g, input logic [1:0] bt, input logic [8:0] bv);
    @(negedge clk);
    si_valid = 1'b1; si_grch = g; si_wsf = 1'b1; si_bt = bt; si_mbf = 1'b0; si_bv = bv;
    @(negedge clk);
    si_valid = 1'b0;
  endtask

  // Start an unloaded or already completed bank. Expect a one-cycle err and no run.
  task automatic start_expect_err(input string tag, input logic [1:0] g);
    @(negedge clk);
    start = 1'b1; start_grch = g;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, "_err"}, err, 1);
    check({tag, "_busy"}, busy, 0);
    @(negedge clk);
    #1;
    check({tag, "_err_pulse"}, err, 0);
  endtask

  // One full run. The bank is loaded either beforehand or in the start cycle.
  // stall_at < 0 means no stall. When inj_k >= 0, cycle inj_k carries a
  // blocked write to the active bank and an ignored start.
  task automatic run_seq(input string tag, input logic [1:0] g, input logic [1:0] bt,
                         input logic [8:0] bv, input logic same_cycle,
                         input int stall_at, input int stall_len, input int inj_k);
    int n, exp_done, issued, first_k, done_k, err_k, err_cnt, stalled;
    int bad_order, bad_grch, bad_stall, bad_field;
    n = exp_n(int'(bv));
    exp_done = (n == 0) ? 3 : n + 5 + stall_len;
    issued = 0; first_k = -1; done_k = -1; err_k = -1; err_cnt = 0; stalled = 0;
    bad_order = 0; bad_grch = 0; bad_stall = 0; bad_field = 0;
    if (!same_cycle) load_bank(g, bt, bv);
    else @(negedge clk);
    // Cycle 0: the start request.
    start = 1'b1; start_grch = g;
    if (same_cycle) begin
      si_valid = 1'b1; si_grch = g; si_wsf = 1'b1; si_bt = bt; si_mbf = 1'b0; si_bv = bv;
    end
    for (int k = 1; k <= 1200 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0; start_grch = 2'd0; si_valid = 1'b0;
      if (k == inj_k) begin
        si_valid = 1'b1; si_grch = g; si_wsf = 1'b0; si_bt = 2'd3; si_mbf = 1'b1; si_bv = 9'h1ff;
        start = 1'b1; start_grch = g + 2'd1;
      end
      stall = 1'b0;
      if (stall_at >= 0 && issued == stall_at && stalled < stall_len) begin
        stall = 1'b1;
        stalled++;
      end
      #1;
      if (din_v) begin
        if (first_k < 0) first_k = k;
        if (int'(is_pos) != issued) bad_order++;
        if (grch_out != g) bad_grch++;
        if (stall) bad_stall++;
        issued++;
      end
      if (busy && ({window_switching_flag, block_type, mixed_block_flag, big_values}
                   != {1'b1, bt, 1'b0, bv})) bad_field++;
      if (err) begin
        err_cnt++;
        if (err_k < 0) err_k = k;
      end
      if (done) done_k = k;
    end
    stall = 1'b0;
    check({tag, "_issued"},    issued, n);
    check({tag, "_order"},     bad_order, 0);
    check({tag, "_grch"},      bad_grch, 0);
    check({tag, "_stall_iss"}, bad_stall, 0);
    check({tag, "_fields"},    bad_field, 0);
    check({tag, "_first_lat"}, first_k, (n > 0) ? 1 : -1);
    check({tag, "_done_lat"},  done_k, exp_done);
    if (inj_k >= 0) begin
      check({tag, "_err_cnt"}, err_cnt, 1);
      check({tag, "_err_cyc"}, err_k, inj_k + 1);
    end else begin
      check({tag, "_err_cnt"}, err_cnt, 0);
    end
    @(negedge clk);
    #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int stall_at;
    int found;
    int err_seen;
    int done_seen;
    rst_n = 1'b0; si_valid = 1'b0; si_grch = '0; si_wsf = 1'b0; si_bt = '0;
    si_mbf = 1'b0; si_bv = '0; start = 1'b0; start_grch = '0; stall = 1'b0;

    // Reset state.
    #12;
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_err",    err, 0);
    check("rst_din_v",  din_v, 0);
    check("rst_is_pos", is_pos, 0);
    check("rst_grch",   grch_out, 0);
    check("rst_fields", {window_switching_flag, block_type, mixed_block_flag, big_values}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start on a bank that was never loaded.
    start_expect_err("unloaded", 2'd2);

    // Plain run on bank 1. Afterwards its loaded bit is clear.
    run_seq("plain", 2'd1, 2'd1, 9'd100, 1'b0, -1, 0, -1);
    start_expect_err("reuse", 2'd1);

    // Stalled run with a blocked write and an ignored start mid-run.
    stall_at = (exp_n(100) > 300) ? 300 : 100;
    run_seq("stall", 2'd1, 2'd1, 9'd100, 1'b0, stall_at, 10, 50);

    // Write and start on the same bank in the same cycle.
    run_seq("same", 2'd3, 2'd2, 9'd100, 1'b1, -1, 0, -1);

    // big_values boundaries.
    run_seq("bv0",   2'd0, 2'd0, 9'd0,   1'b0, -1, 0, -1);
    run_seq("bv400", 2'd2, 2'd3, 9'd400, 1'b0, -1, 0, -1);

    // Reset in the middle of a run.
    load_bank(2'd1, 2'd1, 9'd300);
    @(negedge clk);
    start = 1'b1; start_grch = 2'd1;
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (din_v && is_pos == 10'd250) found = 1;
    end
    check("mid_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",   busy, 0);
    check("mid_din_v",  din_v, 0);
    check("mid_is_pos", is_pos, 0);
    check("mid_grch",   grch_out, 0);
    check("mid_fields", {window_switching_flag, block_type, mixed_block_flag, big_values}, 0);
    check("mid_done",   done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    err_seen = 0; done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (err)  err_seen++;
      if (done) done_seen++;
    end
    check("late_rd_err", (err_seen > 0) ? 1 : 0, 1);
    check("abort_no_done", done_seen, 0);
    start_expect_err("after_rst", 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
